qchannel_ctrl: RTL and testbench
================================

Name: qchannel_ctrl

Overview:
Parametrised Q-Channel low-power controller that wraps any Wishbone slave core in the peripheral subsystem. It sits between the bus and the core. It gates bus inputs and pad inputs to the core when the core is not running. It tracks N core busy sources, enforces a configurable idle hysteresis before accepting quiescence, and denies requests on wake events or timeout via qdeny. It raises qactive on wake-up demand and error-terminates bus accesses issued while the core is stopped or draining.

Parameters:
ADR_W, 5, Wishbone address width
DAT_W, 32, Wishbone data width
SEL_W, 4, byte-select width
NUM_BUSY, 2, number of core busy inputs (at least 1)
NUM_PAD, 1, number of gated pad inputs (at least 1)
ENTRY_DELAY, 2, consecutive quiescent cycles required before accept (at least 1)
DENY_TIMEOUT, 64, cycles in DRAIN before deny; 0 disables the timeout
NUM_WAKE, 1, number of wake-request inputs (at least 1)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, asynchronous, active-high
wb_adr_i  in  ADR_W  bus address
wb_dat_i  in  DAT_W  bus write data
wb_sel_i  in  SEL_W  bus byte select
wb_we_i  in  1  bus write enable
wb_stb_i  in  1  bus strobe
wb_cyc_i  in  1  bus cycle
wb_err_o  out  1  error termination from the controller, ORed with core_err_i
wb_ack_o  out  1  equals core_ack_i
core_adr_o, core_dat_o, core_sel_o, core_we_o, core_stb_o, core_cyc_o  out  matching widths  gated bus to the core
core_ack_i  in  1  core acknowledge
core_err_i  in  1  core error
busy_i  in  NUM_BUSY  core activity; any bit high means not quiescent
pad_i  in  NUM_PAD  raw pad inputs
pad_o  out  NUM_PAD  gated pad inputs to the core
wake_i  in  NUM_WAKE  wake or deny sources
qreqn  in  1  Q-Channel request, active-low
qacceptn  out  1  Q-Channel accept, active-low
qdeny  out  1  Q-Channel deny
qactive  out  1  Q-Channel activity / wake request
state_o  out  3  current state, for debug

Behaviour:
- States: STOPPED=0, RUN=1, DRAIN=2, HOLD=3, DENIED=4. All outputs are registered except the gating muxes.
- Reset (asynchronous) values:
  - state=STOPPED, qacceptn=0, qdeny=0, qactive=0, wb_err_o=0.
  - Gated outputs are 0.
  - Counters are 0 and the lock flag is 0.
- Gating:
  - core_* outputs pass the bus through when state is RUN or DENIED, or when the lock flag is set. Otherwise all core_* outputs are 0.
  - pad_o=pad_i in every state except STOPPED; in STOPPED, pad_o=0.
- Lock flag:
  - Set on the RUN→DRAIN transition if wb_cyc_i=1.
  - Cleared when wb_cyc_i=0.
  - An in-flight bus cycle therefore completes through DRAIN.
- Error termination:
  - Condition: wb_cyc_i&wb_stb_i while the bus is gated and wb_err_o=0.
  - Response: wb_err_o=1 on the next cycle, for one cycle per strobe.
  - The core never sees the access.
- qactive = registered OR of |wake_i and (wb_cyc_i & !passthrough). It is held at 0 only when RUN.
- Quiescent = (busy_i==0) && !lock && !wb_cyc_i.
- STOPPED:
  - qacceptn=0.
  - qreqn=1 → RUN; qacceptn=1 on the following cycle (Q_EXIT→Q_RUN).
- RUN:
  - qreqn=0 → DRAIN; timeout counter cleared, hysteresis counter cleared.
- DRAIN:
  - The timeout counter increments each cycle.
  - If |wake_i=1: → DENIED. This has priority over everything else in DRAIN.
  - Else if DENY_TIMEOUT≠0 and counter==DENY_TIMEOUT-1 while not quiescent: → DENIED.
  - Else if quiescent: → HOLD.
  - If qreqn returns high (protocol violation): → RUN, with no qdeny.
- HOLD:
  - The hysteresis counter increments while quiescent.
  - Any non-quiescent cycle: → DRAIN; the hysteresis counter clears and the timeout counter keeps its value.
  - Wake has the same priority as in DRAIN.
  - When the counter reaches ENTRY_DELAY-1: → STOPPED, qacceptn=0 on the next cycle.
- DENIED:
  - qdeny=1, qacceptn=1, full pass-through.
  - Stays until qreqn=1, then → RUN with qdeny=0 on the next cycle (Q_CONTINUE).
- Acceptance timing: qacceptn never falls while any busy_i bit is set or a bus cycle is open.
- Counter widths: $clog2(max(DENY_TIMEOUT,ENTRY_DELAY))+1 bits. Counters saturate and never wrap.
- Reset mid-operation returns to STOPPED immediately and drops qdeny and wb_err_o asynchronously.

Test Plan:
1. Reset, then qreqn=1 → qacceptn rises 2 cycles after qreqn. A write to adr 0x04 reaches core_* unmodified; wb_ack_o follows core_ack_i.
2. busy_i=2'b01 for 10 cycles, qreqn=0 at cycle 0 (ENTRY_DELAY=2) → qacceptn=0 exactly at cycle 10+1+2. pad_o=0 afterwards.
3. qreqn=0 with busy_i held high, DENY_TIMEOUT=64 → qdeny=1 after 64 DRAIN cycles. qreqn=1 → qdeny=0 next cycle, state RUN.
4. STOPPED, wb_cyc_i=wb_stb_i=1 → wb_err_o one-cycle pulse, core_stb_o stays 0, qactive=1 the cycle after.
5. qreqn=0 during an open bus cycle → core_cyc_o stays 1 until the core acks. Accept only after cyc drops plus ENTRY_DELAY. wake_i=1 in HOLD → DENIED.
6. Assert wb_rst_i asynchronously in DENIED → qdeny=0, qacceptn=0 before the next clock edge.

Source files
------------

// File: rtl/qchannel_ctrl.sv
// qchannel_ctrl: Q-Channel low-power controller gating a Wishbone slave core and its pad inputs.
module qchannel_ctrl #(
  parameter int ADR_W        = 5,
  parameter int DAT_W        = 32,
  parameter int SEL_W        = 4,
  parameter int NUM_BUSY     = 2,
  parameter int NUM_PAD      = 1,
  parameter int ENTRY_DELAY  = 2,
  parameter int DENY_TIMEOUT = 64,
  parameter int NUM_WAKE     = 1
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [ADR_W-1:0]    wb_adr_i,
  input  logic [DAT_W-1:0]    wb_dat_i,
  input  logic [SEL_W-1:0]    wb_sel_i,
  input  logic                wb_we_i,
  input  logic                wb_stb_i,
  input  logic                wb_cyc_i,
  output logic                wb_err_o,
  output logic                wb_ack_o,
  output logic [ADR_W-1:0]    core_adr_o,
  output logic [DAT_W-1:0]    core_dat_o,
  output logic [SEL_W-1:0]    core_sel_o,
  output logic                core_we_o,
  output logic                core_stb_o,
  output logic                core_cyc_o,
  input  logic                core_ack_i,
  input  logic                core_err_i,
  input  logic [NUM_BUSY-1:0] busy_i,
  input  logic [NUM_PAD-1:0]  pad_i,
  output logic [NUM_PAD-1:0]  pad_o,
  input  logic [NUM_WAKE-1:0] wake_i,
  input  logic                qreqn,
  output logic                qacceptn,
  output logic                qdeny,
  output logic                qactive,
  output logic [2:0]          state_o
);
  localparam int MAXV = DENY_TIMEOUT > ENTRY_DELAY ? DENY_TIMEOUT : ENTRY_DELAY;
  localparam int CW = $clog2(MAXV) + 1;
  localparam logic [CW-1:0] T_LAST = CW'(DENY_TIMEOUT - 1);
  localparam logic [CW:0] H_LAST = (CW + 1)'(ENTRY_DELAY - 1);
  localparam logic [2:0] STOPPED = 3'd0, RUN = 3'd1, DRAIN = 3'd2, HOLD = 3'd3, DENIED = 3'd4;
  logic [2:0] state, nxt;
  logic [CW-1:0] tcnt, hcnt, tcnt_d, hcnt_d;
  logic lock, lock_d, err_q, err_d, acc_q, acc_d, deny_q, deny_d, act_q, act_d;
  logic pass, quiet, wake, timeout, hold_done;
  assign wake = |wake_i;
  assign pass = state == RUN || state == DENIED || lock;
  assign quiet = busy_i == '0 && !lock && !wb_cyc_i;
  assign timeout = DENY_TIMEOUT != 0 && tcnt == T_LAST && !quiet;
  // the entering DRAIN cycle already counts as one quiescent cycle
  assign hold_done = ({1'b0, hcnt} + (CW + 1)'(1)) >= H_LAST;
  assign core_adr_o = pass ? wb_adr_i : '0;
  assign core_dat_o = pass ? wb_dat_i : '0;
  assign core_sel_o = pass ? wb_sel_i : '0;
  assign core_we_o  = pass && wb_we_i;
  assign core_stb_o = pass && wb_stb_i;
  assign core_cyc_o = pass && wb_cyc_i;
  assign pad_o = state == STOPPED ? '0 : pad_i;
  assign wb_ack_o = core_ack_i;
  assign wb_err_o = err_q || core_err_i;
  assign qacceptn = acc_q;
  assign qdeny = deny_q;
  assign qactive = act_q;
  assign state_o = state;
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state  <= STOPPED;
      tcnt   <= '0;
      hcnt   <= '0;
      lock   <= 1'b0;
      err_q  <= 1'b0;
      acc_q  <= 1'b0;
      deny_q <= 1'b0;
      act_q  <= 1'b0;
    end else begin
      state  <= nxt;
      tcnt   <= tcnt_d;
      hcnt   <= hcnt_d;
      lock   <= lock_d;
      err_q  <= err_d;
      acc_q  <= acc_d;
      deny_q <= deny_d;
      act_q  <= act_d;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      STOPPED: nxt = qreqn ? RUN : STOPPED;
      RUN:     nxt = qreqn ? RUN : DRAIN;
      DRAIN:   nxt = wake ? DENIED : qreqn ? RUN : timeout ? DENIED : quiet ? HOLD : DRAIN;
      HOLD:    nxt = wake ? DENIED : qreqn ? RUN : !quiet ? DRAIN : hold_done ? STOPPED : HOLD;
      DENIED:  nxt = qreqn ? RUN : DENIED;
      default: nxt = STOPPED;
    endcase
  end
  always_comb begin
    acc_d  = state != STOPPED;
    deny_d = state == DENIED;
    act_d  = state != RUN && (wake || (wb_cyc_i && !pass));
    err_d  = wb_cyc_i && wb_stb_i && !pass && !err_q;
    lock_d = wb_cyc_i && (lock || (state == RUN && nxt == DRAIN));
    tcnt_d = state == RUN ? '0 : (state == DRAIN && !(&tcnt)) ? tcnt + CW'(1) : tcnt;
    hcnt_d = (state == HOLD && quiet) ? (&hcnt ? hcnt : hcnt + CW'(1)) : '0;
  end
endmodule

// File: tb/tb_qchannel_ctrl.sv
// tb_qchannel_ctrl: scoreboard-driven bench for the Q-Channel controller.
module tb_qchannel_ctrl;
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b1;
  logic [4:0] wb_adr_i = '0, core_adr_o;
  logic [31:0] wb_dat_i = '0, core_dat_o;
  logic [3:0] wb_sel_i = '0, core_sel_o;
  logic wb_we_i = 1'b0, wb_stb_i = 1'b0, wb_cyc_i = 1'b0, wb_err_o, wb_ack_o;
  logic core_we_o, core_stb_o, core_cyc_o, core_ack_i = 1'b0, core_err_i = 1'b0;
  logic [1:0] busy_i = '0;
  logic [0:0] pad_i = 1'b1, pad_o, wake_i = 1'b0;
  logic qreqn = 1'b0, qacceptn, qdeny, qactive;
  logic [2:0] state_o;
  int errors = 0, checks = 0;
  localparam int ST = 0, ACC = 1, DNY = 2, ACT = 3, ERR = 4, CSTB = 5, CCYC = 6, CADR = 7, CDAT = 8, ACK = 9, PAD = 10;
  typedef struct {string tag; int id; logic [31:0] v;} sb_t;
  sb_t sbq[$];
  qchannel_ctrl dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_err_o(wb_err_o), .wb_ack_o(wb_ack_o), .core_adr_o(core_adr_o), .core_dat_o(core_dat_o),
    .core_sel_o(core_sel_o), .core_we_o(core_we_o), .core_stb_o(core_stb_o), .core_cyc_o(core_cyc_o),
    .core_ack_i(core_ack_i), .core_err_i(core_err_i), .busy_i(busy_i), .pad_i(pad_i), .pad_o(pad_o),
    .wake_i(wake_i), .qreqn(qreqn), .qacceptn(qacceptn), .qdeny(qdeny), .qactive(qactive),
    .state_o(state_o)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] probe(input int id);
    case (id)
      ST:      return 32'(state_o);
      ACC:     return 32'(qacceptn);
      DNY:     return 32'(qdeny);
      ACT:     return 32'(qactive);
      ERR:     return 32'(wb_err_o);
      CSTB:    return 32'(core_stb_o);
      CCYC:    return 32'(core_cyc_o);
      CADR:    return 32'(core_adr_o);
      CDAT:    return core_dat_o;
      ACK:     return 32'(wb_ack_o);
      PAD:     return 32'(pad_o);
      default: return 'x;
    endcase
  endfunction
  task automatic want(input string tag, input int id, input logic [31:0] v);
    sbq.push_back('{tag, id, v});
  endtask
  task automatic settle();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, probe(e.id), e.v);
    end
  endtask
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
    settle();
  endtask
  initial begin
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    want("rst_state", ST, 0); want("rst_acc", ACC, 0); want("rst_deny", DNY, 0);
    want("rst_act", ACT, 0); want("rst_err", ERR, 0); want("rst_stb", CSTB, 0); want("rst_pad", PAD, 0);
    settle();
    // bring-up handshake and a pass-through write
    qreqn = 1'b1;
    want("t1_run", ST, 1); want("t1_acc_lo", ACC, 0);
    tick();
    want("t1_acc_hi", ACC, 1);
    tick();
    wb_adr_i = 5'h04; wb_dat_i = 32'hdeadbeef; wb_sel_i = 4'hf; wb_we_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; core_ack_i = 1'b1;
    want("t1_adr", CADR, 32'h4); want("t1_dat", CDAT, 32'hdeadbeef); want("t1_stb", CSTB, 1);
    want("t1_ack", ACK, 1); want("t1_pad", PAD, 1); want("t1_act", ACT, 0);
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; core_ack_i = 1'b0; wb_we_i = 1'b0;
    // busy for 10 cycles then hysteresis
    busy_i = 2'b01; qreqn = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 1 || i == 10) want("t2_drain", ST, 2);
      tick();
    end
    busy_i = 2'b00;
    want("t2_hold", ST, 3);
    tick();
    want("t2_stop", ST, 0); want("t2_acc_still", ACC, 1);
    tick();
    want("t2_acc_lo", ACC, 0); want("t2_pad", PAD, 0);
    tick();
    // access while stopped
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 5'h08;
    want("t4_gate_stb", CSTB, 0);
    settle();
    want("t4_err", ERR, 1); want("t4_act", ACT, 1); want("t4_gate_stb2", CSTB, 0);
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    want("t4_err_off", ERR, 0); want("t4_act_off", ACT, 0);
    tick();
    // deny timeout
    qreqn = 1'b1;
    tick();
    want("t3_acc_hi", ACC, 1);
    tick();
    busy_i = 2'b10; qreqn = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      if (i == 64) begin want("t3_drain64", ST, 2); want("t3_nodeny", DNY, 0); end
      tick();
    end
    want("t3_denied", ST, 4);
    tick();
    want("t3_deny", DNY, 1); want("t3_acc", ACC, 1);
    tick();
    qreqn = 1'b1;
    want("t3_run", ST, 1); want("t3_deny_hold", DNY, 1);
    tick();
    want("t3_deny_off", DNY, 0);
    tick();
    busy_i = 2'b00;
    // draining an open bus cycle, then wake in HOLD
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_adr_i = 5'h0c; qreqn = 1'b0;
    want("t5_drain", ST, 2); want("t5_cyc", CCYC, 1); want("t5_stb", CSTB, 1); want("t5_noerr", ERR, 0);
    tick();
    want("t5_cyc2", CCYC, 1); want("t5_acc", ACC, 1);
    tick();
    core_ack_i = 1'b1;
    #1;
    want("t5_ack", ACK, 1);
    settle();
    tick();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; core_ack_i = 1'b0;
    want("t5_still_drain", ST, 2);
    tick();
    want("t5_hold", ST, 3);
    tick();
    wake_i = 1'b1;
    want("t5_wake_deny", ST, 4); want("t5_acc_keep", ACC, 1);
    tick();
    want("t5_deny", DNY, 1); want("t5_qact", ACT, 1);
    tick();
    // asynchronous reset in DENIED
    #2;
    wb_rst_i = 1'b1;
    #1;
    want("t6_deny", DNY, 0); want("t6_acc", ACC, 0); want("t6_state", ST, 0); want("t6_err", ERR, 0);
    settle();
    wake_i = 1'b0;
    @(posedge wb_clk_i);
    #1;
    wb_rst_i = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
